dp_seq_buffer: RTL

- Data processor feeding the PE array controller.
- Holds the query S in a symbol store and the database T in a ring buffer of {t, v, f} entries. It streams S and T heads to the controller and appends the controller's per-pass T/V/F writebacks to the ring, so they become the next pass's T input.
- The host loads S and T once, pulses start, and the block streams until the final pass completes.

---
 rtl/dp_seq_buffer_if.sv | 48 ++++
 rtl/dp_seq_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dp_seq_buffer_if.sv
// Host/controller bus of dp_seq_buffer: load port, S/T head stream and writeback port.
// pass_cnt exists only when DP_PASS_COUNT_EN is defined.
interface dp_seq_buffer_if #(
  parameter int VEF_W = 16
);
  logic             load_valid;
  logic             load_ready;
  logic             load_sel;
  logic [1:0]       load_sym;
  logic             start;
  logic             result_valid;
  logic             busy;
  logic             err;
  logic             data_valid;
  logic             update_s;
  logic [1:0]       s;
  logic             s_last;
  logic             update_t;
  logic [1:0]       t;
  logic [VEF_W-1:0] v;
  logic [VEF_W-1:0] f;
  logic             t_last;
  logic             wb_valid;
  logic [1:0]       wb_t;
  logic [VEF_W-1:0] wb_v;
  logic [VEF_W-1:0] wb_f;
`ifdef DP_PASS_COUNT_EN
  logic [15:0]      pass_cnt;
`endif

  modport master (
    output load_valid, load_sel, load_sym, start, result_valid,
           update_s, update_t, wb_valid, wb_t, wb_v, wb_f,
    input  load_ready, busy, err, data_valid, s, s_last, t, v, f, t_last
`ifdef DP_PASS_COUNT_EN
    , input pass_cnt
`endif
  );

  modport slave (
    input  load_valid, load_sel, load_sym, start, result_valid,
           update_s, update_t, wb_valid, wb_t, wb_v, wb_f,
    output load_ready, busy, err, data_valid, s, s_last, t, v, f, t_last
`ifdef DP_PASS_COUNT_EN
    , output pass_cnt
`endif
  );
endinterface

// File: rtl/dp_seq_buffer.sv
// Query (S) symbol store plus database (T) ring buffer streaming heads to the PE array controller.
// Define DP_PASS_COUNT_EN to add the saturating pass counter output pass_cnt.
module dp_seq_buffer #(
  parameter int VEF_W   = 16,
  parameter int S_DEPTH = 1024,
  parameter int T_DEPTH = 1024,
  parameter int S_AW    = 10,
  parameter int T_AW    = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  dp_seq_buffer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STREAM, ST_DRAIN} state_t;

  typedef struct packed {
    logic [1:0]       t;
    logic [VEF_W-1:0] v;
    logic [VEF_W-1:0] f;
  } entry_t;

  localparam logic [S_AW:0] S_FULL = (S_AW+1)'(S_DEPTH);
  localparam logic [T_AW:0] T_FULL = (T_AW+1)'(T_DEPTH);

  state_t          state_q, state_d;
  logic [S_AW:0]   s_len_q;
  logic [S_AW-1:0] s_rd_q;
  logic            s_done_q;
  logic [T_AW:0]   t_len_q, t_idx_q, count_q;
  logic [T_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic            busy_q, err_q;

  logic [1:0] s_mem [S_DEPTH];
  entry_t     ring  [T_DEPTH];
  entry_t     head, wr_entry;

  logic load_phase, streaming, tgt_full, load_fire, load_drop, s_load, t_load;
  logic data_valid, s_is_last, t_is_last, cons_s, cons_t;
  logic wb_push, wb_drop, ring_we, drain_exit;

  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    load_phase = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    streaming  = (state_q == ST_STREAM);
    tgt_full   = bus.load_sel ? (count_q == T_FULL) : (s_len_q == S_FULL);
    load_fire  = load_phase && bus.load_valid && !tgt_full;
    load_drop  = load_phase && bus.load_valid && tgt_full;
    s_load     = load_fire && !bus.load_sel;
    t_load     = load_fire && bus.load_sel;
    data_valid = streaming && (count_q != '0);
    s_is_last  = ({1'b0, s_rd_q} == s_len_q - 1'b1);
    t_is_last  = (t_idx_q == t_len_q - 1'b1);
    // Once the last S is taken the S head freezes, so later S updates are no-ops.
    cons_s     = data_valid && bus.update_s && !s_done_q;
    cons_t     = data_valid && bus.update_t;
    wb_push    = streaming && bus.wb_valid && (count_q != T_FULL);
    wb_drop    = streaming && bus.wb_valid && (count_q == T_FULL);
    ring_we    = t_load || wb_push;
    wr_entry   = t_load ? entry_t'{t: bus.load_sym, v: '0, f: '0}
                        : entry_t'{t: bus.wb_t, v: bus.wb_v, f: bus.wb_f};
    drain_exit = (state_q == ST_DRAIN) && bus.result_valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.load_valid) state_d = ST_LOAD;
      ST_LOAD:   if (bus.start && (s_len_q != '0) && (t_len_q != '0)) state_d = ST_STREAM;
      ST_STREAM: if (cons_t && t_is_last && (s_done_q || (cons_s && s_is_last)))
                   state_d = ST_DRAIN;
      ST_DRAIN:  if (bus.result_valid) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      s_len_q  <= '0;
      s_rd_q   <= '0;
      s_done_q <= 1'b0;
      t_len_q  <= '0;
      t_idx_q  <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_q == ST_STREAM) || (state_q == ST_DRAIN);
      if (load_drop || wb_drop) err_q <= 1'b1;
      if (drain_exit) begin
        s_len_q  <= '0;
        s_rd_q   <= '0;
        s_done_q <= 1'b0;
        t_len_q  <= '0;
        t_idx_q  <= '0;
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (s_load)  s_len_q  <= s_len_q + 1'b1;
        if (t_load)  t_len_q  <= t_len_q + 1'b1;
        if (ring_we) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (cons_t) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          t_idx_q  <= t_is_last ? '0 : t_idx_q + 1'b1;
        end
        if (cons_s) begin
          if (s_is_last) s_done_q <= 1'b1;
          else           s_rd_q   <= s_rd_q + 1'b1;
        end
        case ({ring_we, cons_t})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // NOTE: storage arrays have no reset; their contents are only read after being written.
  always_ff @(posedge clk) begin
    if (s_load)  s_mem[s_len_q[S_AW-1:0]] <= bus.load_sym;
    if (ring_we) ring[wr_ptr_q]           <= wr_entry;
  end

  assign head           = ring[rd_ptr_q];
  assign bus.load_ready = load_phase && !tgt_full;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
  assign bus.data_valid = data_valid;
  assign bus.s          = streaming ? s_mem[s_rd_q] : '0;
  assign bus.s_last     = streaming && s_is_last;
  assign bus.t          = streaming ? head.t : '0;
  assign bus.v          = streaming ? head.v : '0;
  assign bus.f          = streaming ? head.f : '0;
  assign bus.t_last     = streaming && t_is_last;

`ifdef DP_PASS_COUNT_EN
  logic [15:0] pass_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
    end else if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) begin
      pass_cnt_q <= '0;
    end else if (cons_t && t_is_last && (pass_cnt_q != 16'hFFFF)) begin
      pass_cnt_q <= pass_cnt_q + 1'b1;
    end
  end

  assign bus.pass_cnt = pass_cnt_q;
`endif

endmodule
